// File: rtl/stack_core.sv
// Three-cycle-per-instruction stack machine: fetch, load IR, execute against an
// on-chip data stack. HALT and FAULT are sticky until reset.
module stack_core #(
  parameter int unsigned DWIDTH      = 16,
  parameter int unsigned AWIDTH      = 10,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [AWIDTH-1:0]              imem_addr,
  output logic                           imem_rd,
  input  logic [15:0]                    imem_rdata,
  output logic                           halted,
  output logic                           fault,
  output logic [DWIDTH-1:0]              tos,
  output logic [$clog2(STACK_DEPTH):0]   sp
);

  localparam int unsigned SpW  = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned IdxW = SpW - 1;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpPushi = 4'h1;
  localparam logic [3:0] OpPop  = 4'h2;
  localparam logic [3:0] OpAdd  = 4'h3;
  localparam logic [3:0] OpSub  = 4'h4;
  localparam logic [3:0] OpJmp  = 4'h5;
  localparam logic [3:0] OpJz   = 4'h6;
  localparam logic [3:0] OpDup  = 4'h7;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [2:0] {StFetch, StLoad, StExec, StHalt, StFault} state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   ip_q, ip_d;
  logic [15:0]         ir_q, ir_d;
  logic [SpW-1:0]      sp_q, sp_d;
  logic [DWIDTH-1:0]   stack_q [STACK_DEPTH];

  logic                we;
  logic [IdxW-1:0]     wr_idx;
  logic [DWIDTH-1:0]   wr_data;
  logic                err;

  logic [3:0]          opcode;
  logic [11:0]         operand;
  logic [DWIDTH-1:0]   imm;
  logic [AWIDTH-1:0]   target;
  logic [IdxW-1:0]     idx_m1, idx_m2;
  logic [DWIDTH-1:0]   top_val, next_val;
  logic                empty, lt2, full;

  assign opcode   = ir_q[15:12];
  assign operand  = ir_q[11:0];
  assign imm      = DWIDTH'(operand);
  assign target   = operand[AWIDTH-1:0];
  assign idx_m1   = sp_q[IdxW-1:0] - IdxW'(1);
  assign idx_m2   = sp_q[IdxW-1:0] - IdxW'(2);
  assign top_val  = stack_q[idx_m1];
  assign next_val = stack_q[idx_m2];
  assign empty    = (sp_q == '0);
  assign lt2      = (sp_q < SpW'(2));
  assign full     = (sp_q == SpW'(STACK_DEPTH));

  assign imem_rd   = (state_q == StFetch);
  assign imem_addr = ip_q;
  assign halted    = (state_q == StHalt);
  assign fault     = (state_q == StFault);
  assign tos       = empty ? '0 : top_val;
  assign sp        = sp_q;

  always_comb begin
    state_d = state_q;
    ip_d    = ip_q;
    ir_d    = ir_q;
    sp_d    = sp_q;
    we      = 1'b0;
    wr_idx  = sp_q[IdxW-1:0];
    wr_data = imm;
    err     = 1'b0;
    unique case (state_q)
      StFetch: state_d = StLoad;
      StLoad: begin
        ir_d    = imem_rdata;
        ip_d    = ip_q + 1'b1;
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        case (opcode)
          OpNop: ;
          OpPushi: begin
            if (full) err = 1'b1;
            else begin
              we   = 1'b1;
              sp_d = sp_q + 1'b1;
            end
          end
          OpPop: begin
            if (empty) err = 1'b1;
            else sp_d = sp_q - 1'b1;
          end
          OpAdd, OpSub: begin
            if (lt2) err = 1'b1;
            else begin
              // Result overwrites the second operand's slot; net effect is one pop.
              we      = 1'b1;
              wr_idx  = idx_m2;
              wr_data = (opcode == OpAdd) ? next_val + top_val : next_val - top_val;
              sp_d    = sp_q - 1'b1;
            end
          end
          OpJmp: ip_d = target;
          OpJz: begin
            if (empty) err = 1'b1;
            else begin
              sp_d = sp_q - 1'b1;
              if (top_val == '0) ip_d = target;
            end
          end
          OpDup: begin
            if (full || empty) err = 1'b1;
            else begin
              we      = 1'b1;
              wr_data = top_val;
              sp_d    = sp_q + 1'b1;
            end
          end
          OpHalt: state_d = StHalt;
          default: err = 1'b1;
        endcase
        if (err) begin
          state_d = StFault;
          we      = 1'b0;
          ip_d    = ip_q;
          sp_d    = sp_q;
        end
      end
      StHalt, StFault: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      ip_q    <= '0;
      ir_q    <= '0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      ir_q    <= ir_d;
      sp_q    <= sp_d;
    end
  end

  // Stack storage is not reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && we) stack_q[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_stack_core.sv
// Directed-program bench for stack_core: a default-parameter instance and a
// narrow instance (DWIDTH=8, AWIDTH=4, STACK_DEPTH=4), each with its own memory.
module tb_stack_core;

  logic clk;
  logic rst_a, rst_b;

  logic [9:0]  addr_a;
  logic        rd_a, halted_a, fault_a;
  logic [15:0] rdata_a, tos_a;
  logic [4:0]  sp_a;

  logic [3:0]  addr_b;
  logic        rd_b, halted_b, fault_b;
  logic [15:0] rdata_b;
  logic [7:0]  tos_b;
  logic [2:0]  sp_b;

  logic [15:0] mem_a [1024];
  logic [15:0] mem_b [16];
  logic [15:0] prog_q [$];

  int reads_a, fetch2_a;
  int n_vec, n_err;
  bit sel;

  logic        cur_halted, cur_fault, cur_rd;
  logic [31:0] cur_tos, cur_sp, cur_addr;

  stack_core u_dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .imem_addr  (addr_a),
    .imem_rd    (rd_a),
    .imem_rdata (rdata_a),
    .halted     (halted_a),
    .fault      (fault_a),
    .tos        (tos_a),
    .sp         (sp_a)
  );

  stack_core #(
    .DWIDTH      (8),
    .AWIDTH      (4),
    .STACK_DEPTH (4)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .imem_addr  (addr_b),
    .imem_rd    (rd_b),
    .imem_rdata (rdata_b),
    .halted     (halted_b),
    .fault      (fault_b),
    .tos        (tos_b),
    .sp         (sp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_a) rdata_a <= mem_a[addr_a];
    if (rd_b) rdata_b <= mem_b[addr_b];
    if (rst_a) begin
      reads_a  <= 0;
      fetch2_a <= 0;
    end else if (rd_a) begin
      reads_a <= reads_a + 1;
      if (addr_a == 10'd2) fetch2_a <= fetch2_a + 1;
    end
  end

  always_comb begin
    cur_halted = sel ? halted_b : halted_a;
    cur_fault  = sel ? fault_b  : fault_a;
    cur_rd     = sel ? rd_b     : rd_a;
    cur_tos    = sel ? 32'(tos_b)  : 32'(tos_a);
    cur_sp     = sel ? 32'(sp_b)   : 32'(sp_a);
    cur_addr   = sel ? 32'(addr_b) : 32'(addr_a);
  end

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] opd);
    return {op, opd};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load prog_q into the selected memory, pulse reset, release on a falling edge.
  task automatic start(input bit s);
    sel = s;
    for (int i = 0; i < 1024; i++) mem_a[i] = '0;
    for (int i = 0; i < 16; i++) mem_b[i] = '0;
    for (int i = 0; i < prog_q.size(); i++) begin
      if (s) mem_b[i] = prog_q[i];
      else   mem_a[i] = prog_q[i];
    end
    if (s) rst_b = 1'b1;
    else   rst_a = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(cur_halted || cur_fault) && n < 300) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(cur_halted | cur_fault), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    sel   = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // SUB sequence with exact halt latency, plus reset-state checks.
    prog_q = {ins(1, 5), ins(1, 3), ins(4, 0), ins(15, 0)};
    start(1'b0);
    check("rst_rd", 32'(cur_rd), 32'd1);
    check("rst_addr", cur_addr, 32'd0);
    check("rst_tos", cur_tos, 32'd0);
    check("rst_sp", cur_sp, 32'd0);
    check("rst_halted", 32'(cur_halted), 32'd0);
    check("rst_fault", 32'(cur_fault), 32'd0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("sub_halt_early", 32'(cur_halted), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("sub_halted", 32'(cur_halted), 32'd1);
    check("sub_tos", cur_tos, 32'd2);
    check("sub_sp", cur_sp, 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("halt_rd", 32'(cur_rd), 32'd0);
    check("halt_reads", 32'(reads_a), 32'd4);
    check("halt_sticky", 32'(cur_halted), 32'd1);

    // JZ taken: address 2 is skipped.
    prog_q = {ins(1, 0), ins(6, 4), ins(1, 9), ins(15, 0), ins(1, 7), ins(15, 0)};
    start(1'b0);
    wait_done("jz_t");
    check("jz_t_halted", 32'(cur_halted), 32'd1);
    check("jz_t_tos", cur_tos, 32'd7);
    check("jz_t_sp", cur_sp, 32'd1);
    check("jz_t_skip", 32'(fetch2_a), 32'd0);

    // JZ not taken still pops.
    prog_q = {ins(1, 1), ins(6, 5), ins(1, 12'hAB), ins(15, 0), 16'h0000,
              ins(1, 12'hEE), ins(15, 0)};
    start(1'b0);
    wait_done("jz_n");
    check("jz_n_tos", cur_tos, 32'hAB);
    check("jz_n_sp", cur_sp, 32'd1);

    // DUP, ADD, POP.
    prog_q = {ins(1, 12'h123), ins(7, 0), ins(3, 0), ins(1, 7), ins(2, 0), ins(15, 0)};
    start(1'b0);
    wait_done("dup");
    check("dup_tos", cur_tos, 32'h246);
    check("dup_sp", cur_sp, 32'd1);

    // SUB borrow wraps modulo 2^16.
    prog_q = {ins(1, 3), ins(1, 5), ins(4, 0), ins(15, 0)};
    start(1'b0);
    wait_done("subw");
    check("subw_tos", cur_tos, 32'hFFFE);

    // ADD on empty stack.
    prog_q = {ins(3, 0)};
    start(1'b0);
    wait_done("add_e");
    check("add_e_fault", 32'(cur_fault), 32'd1);
    check("add_e_halted", 32'(cur_halted), 32'd0);
    check("add_e_sp", cur_sp, 32'd0);

    // Illegal opcode 9 leaves the stack intact.
    prog_q = {ins(1, 1), 16'h9000};
    start(1'b0);
    wait_done("op9");
    check("op9_fault", 32'(cur_fault), 32'd1);
    check("op9_sp", cur_sp, 32'd1);
    check("op9_tos", cur_tos, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("fault_rd", 32'(cur_rd), 32'd0);

    // Reset during EXEC of the first PUSHI aborts it.
    prog_q = {ins(1, 5), ins(1, 3), ins(4, 0), ins(15, 0)};
    start(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    check("abort_sp", cur_sp, 32'd0);
    check("abort_tos", cur_tos, 32'd0);
    check("abort_addr", cur_addr, 32'd0);
    check("abort_rd", 32'(cur_rd), 32'd1);
    wait_done("abort");
    check("abort_tos_end", cur_tos, 32'd2);
    check("abort_sp_end", cur_sp, 32'd1);

    // Narrow instance: overflow at depth 4.
    prog_q = {ins(1, 12'h11), ins(1, 12'h22), ins(1, 12'h33), ins(1, 12'h44), ins(1, 12'h55)};
    start(1'b1);
    wait_done("ovf");
    check("ovf_fault", 32'(cur_fault), 32'd1);
    check("ovf_sp", cur_sp, 32'd4);
    check("ovf_tos", cur_tos, 32'h44);

    // 8-bit ADD wrap.
    prog_q = {ins(1, 12'hFF), ins(1, 2), ins(3, 0), ins(15, 0)};
    start(1'b1);
    wait_done("add8");
    check("add8_tos", cur_tos, 32'h01);
    check("add8_sp", cur_sp, 32'd1);

    // Immediate truncated to 8 bits.
    prog_q = {ins(1, 12'hABC), ins(15, 0)};
    start(1'b1);
    wait_done("trunc");
    check("trunc_tos", cur_tos, 32'hBC);

    // DUP on empty stack.
    prog_q = {ins(7, 0)};
    start(1'b1);
    wait_done("dup_e");
    check("dup_e_fault", 32'(cur_fault), 32'd1);
    check("dup_e_sp", cur_sp, 32'd0);

    // JMP to the last address; ip increment wraps the next fetch to 0.
    prog_q = {ins(5, 15)};
    start(1'b1);
    check("wrap_a0", cur_addr, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wrap_a15", cur_addr, 32'd15);
    check("wrap_rd15", 32'(cur_rd), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wrap_addr0", cur_addr, 32'd0);
    check("wrap_rd0", 32'(cur_rd), 32'd1);
    check("wrap_fault", 32'(cur_fault), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
